// File: rtl/montgomery_modexp_ctrl.sv
// -----------------------------------------------------------------------------
// montgomery_modexp_ctrl
//
// Computes X^E mod m by sequencing an external Montgomery multiplier
// (MMM(A,B) = A*B*2^-K_BITS mod m). The run is:
//   Xm  = MMM(X, R2)          -- X into the Montgomery domain
//   ACC = MMM(1, R2)          -- R mod m, i.e. Montgomery "one"
//   for every exponent bit, MSB first (leading zeros included):
//       ACC = MMM(ACC, ACC)
//       if bit set: ACC = MMM(ACC, Xm)
//   ACC = MMM(ACC, 1)         -- back out of the Montgomery domain
//   ACC = (ACC >= m) ? ACC - m : ACC
//
// Multiplier handshake (this block is the initiator):
//   o_Mul_Start is a level request. It rises only while i_Mul_Done is low and
//   stays high until i_Mul_Done is sampled high, at which point i_Mul_P is
//   captured and o_Mul_Start drops. The next request is issued only after
//   i_Mul_Done is sampled low again. o_Mul_A/o_Mul_B/o_Mul_m are registered
//   and never change while o_Mul_Start=1 or i_Mul_Done=1.
//
// Ports
//   i_Clk, i_Rst        clock, asynchronous active-high reset
//   i_Start             run request, sampled in IDLE, held until o_Done seen
//   i_X, i_E, i_m, i_R2 base, exponent, odd modulus, 2^(2*K_BITS) mod m
//   o_Result, o_Done    result (valid while o_Done=1, held in IDLE), done level
//   o_Busy              high in every state except IDLE and DONE
//   o_Mul_Start/A/B/m   multiplier request and operands
//   i_Mul_P, i_Mul_Done multiplier result and done level
//   o_Dbg_State         {state, phase} for observation
// -----------------------------------------------------------------------------
module montgomery_modexp_ctrl #(
    parameter int K_BITS = 256,
    parameter int E_BITS = 256
) (
    input  logic              i_Clk,
    input  logic              i_Rst,
    input  logic              i_Start,
    input  logic [K_BITS-1:0] i_X,
    input  logic [E_BITS-1:0] i_E,
    input  logic [K_BITS-1:0] i_m,
    input  logic [K_BITS-1:0] i_R2,
    output logic [K_BITS-1:0] o_Result,
    output logic              o_Done,
    output logic              o_Busy,
    output logic              o_Mul_Start,
    output logic [K_BITS-1:0] o_Mul_A,
    output logic [K_BITS-1:0] o_Mul_B,
    output logic [K_BITS-1:0] o_Mul_m,
    input  logic [K_BITS-1:0] i_Mul_P,
    input  logic              i_Mul_Done,
    output logic [3:0]        o_Dbg_State
);

    localparam int IDX_W = (E_BITS > 1) ? $clog2(E_BITS) : 1;
    localparam logic [K_BITS-1:0] ONE = {{(K_BITS-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_TO_X   = 3'd1,
        S_TO_ONE = 3'd2,
        S_SQR    = 3'd3,
        S_MUL    = 3'd4,
        S_FROM   = 3'd5,
        S_CORR   = 3'd6,
        S_DONE   = 3'd7
    } state_t;

    // Every multiply state runs ISSUE (request up, wait for done) and then
    // RELEASE (request down, wait for done to clear).
    typedef enum logic {
        PH_ISSUE   = 1'b0,
        PH_RELEASE = 1'b1
    } phase_t;

    state_t            state_q,     state_d;
    phase_t            phase_q,     phase_d;
    logic [IDX_W-1:0]  bit_idx_q,   bit_idx_d;
    logic [E_BITS-1:0] e_q,         e_d;
    logic [K_BITS-1:0] m_q,         m_d;
    logic [K_BITS-1:0] r2_q,        r2_d;
    logic [K_BITS-1:0] xm_q,        xm_d;
    logic [K_BITS-1:0] acc_q,       acc_d;
    logic [K_BITS-1:0] result_q,    result_d;
    logic              mul_start_q, mul_start_d;
    logic [K_BITS-1:0] mul_a_q,     mul_a_d;
    logic [K_BITS-1:0] mul_b_q,     mul_b_d;

    // One extra bit so an ACC up to 2^K_BITS-1 against m compares correctly;
    // the borrow (MSB) set means ACC < m.
    logic [K_BITS:0]   corr_diff;
    logic              corr_ge;
    logic              do_step;

    assign corr_diff = {1'b0, acc_q} - {1'b0, m_q};
    assign corr_ge   = ~corr_diff[K_BITS];

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q     <= S_IDLE;
            phase_q     <= PH_ISSUE;
            bit_idx_q   <= '0;
            e_q         <= '0;
            m_q         <= '0;
            r2_q        <= '0;
            xm_q        <= '0;
            acc_q       <= '0;
            result_q    <= '0;
            mul_start_q <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            bit_idx_q   <= bit_idx_d;
            e_q         <= e_d;
            m_q         <= m_d;
            r2_q        <= r2_d;
            xm_q        <= xm_d;
            acc_q       <= acc_d;
            result_q    <= result_d;
            mul_start_q <= mul_start_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and next-output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        bit_idx_d   = bit_idx_q;
        e_d         = e_q;
        m_d         = m_q;
        r2_d        = r2_q;
        xm_d        = xm_q;
        acc_d       = acc_q;
        result_d    = result_q;
        mul_start_d = mul_start_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        do_step     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_Start) begin
                    e_d         = i_E;
                    m_d         = i_m;
                    r2_d        = i_R2;
                    bit_idx_d   = IDX_W'(E_BITS - 1);
                    // X is only ever needed as the first A operand, so the
                    // operand register doubles as its latch.
                    mul_a_d     = i_X;
                    mul_b_d     = i_R2;
                    mul_start_d = 1'b1;
                    phase_d     = PH_ISSUE;
                    state_d     = S_TO_X;
                end
            end

            S_TO_X, S_TO_ONE, S_SQR, S_MUL, S_FROM: begin
                if (phase_q == PH_ISSUE) begin
                    if (i_Mul_Done) begin
                        if (state_q == S_TO_X) begin
                            xm_d = i_Mul_P;
                        end else begin
                            acc_d = i_Mul_P;
                        end
                        mul_start_d = 1'b0;
                        phase_d     = PH_RELEASE;
                    end
                end else if (!i_Mul_Done) begin
                    // Multiplier has cleared done: pick the next operation.
                    // acc_q already holds the product captured in ISSUE.
                    phase_d = PH_ISSUE;
                    case (state_q)
                        S_TO_X: begin
                            state_d     = S_TO_ONE;
                            mul_a_d     = ONE;
                            mul_b_d     = r2_q;
                            mul_start_d = 1'b1;
                        end
                        S_TO_ONE: begin
                            state_d     = S_SQR;
                            mul_a_d     = acc_q;
                            mul_b_d     = acc_q;
                            mul_start_d = 1'b1;
                        end
                        S_SQR: begin
                            if (e_q[bit_idx_q]) begin
                                state_d     = S_MUL;
                                mul_a_d     = acc_q;
                                mul_b_d     = xm_q;
                                mul_start_d = 1'b1;
                            end else begin
                                do_step = 1'b1;
                            end
                        end
                        S_MUL: begin
                            do_step = 1'b1;
                        end
                        default: begin
                            state_d = S_CORR;
                        end
                    endcase

                    // Advance to the next exponent bit, or leave the domain
                    // once the LSB has been processed.
                    if (do_step) begin
                        if (bit_idx_q == '0) begin
                            state_d     = S_FROM;
                            mul_a_d     = acc_q;
                            mul_b_d     = ONE;
                            mul_start_d = 1'b1;
                        end else begin
                            bit_idx_d   = bit_idx_q - 1'b1;
                            state_d     = S_SQR;
                            mul_a_d     = acc_q;
                            mul_b_d     = acc_q;
                            mul_start_d = 1'b1;
                        end
                    end
                end
            end

            S_CORR: begin
                // The multiplier may return values in [m, 2m); fold them back.
                acc_d    = corr_ge ? corr_diff[K_BITS-1:0] : acc_q;
                result_d = corr_ge ? corr_diff[K_BITS-1:0] : acc_q;
                state_d  = S_DONE;
            end

            S_DONE: begin
                if (!i_Start) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign o_Result    = result_q;
    assign o_Done      = (state_q == S_DONE);
    assign o_Busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign o_Mul_Start = mul_start_q;
    assign o_Mul_A     = mul_a_q;
    assign o_Mul_B     = mul_b_q;
    assign o_Mul_m     = m_q;
    assign o_Dbg_State = {state_q, phase_q};

endmodule

// File: tb/tb_montgomery_modexp_ctrl.sv
// -----------------------------------------------------------------------------
// tb_montgomery_modexp_ctrl
//
// Directed bench for montgomery_modexp_ctrl with K_BITS=E_BITS=8, m=13,
// R2=3 (R = 256 mod 13 = 9). A behavioural Montgomery multiplier answers the
// controller's requests; its latency can be fixed or randomly stretched, and
// it can return P+m on a chosen multiply to exercise the final subtraction.
// -----------------------------------------------------------------------------
module tb_montgomery_modexp_ctrl;

    localparam int K = 8;
    localparam int EB = 8;
    localparam logic [K-1:0] MOD = 8'd13;
    localparam logic [K-1:0] R2 = 8'd3;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rst;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic          start;
    logic [K-1:0]  x;
    logic [EB-1:0] e;
    logic [K-1:0]  m;
    logic [K-1:0]  r2;
    logic [K-1:0]  result;
    logic          done;
    logic          busy;
    logic          mul_start;
    logic [K-1:0]  mul_a;
    logic [K-1:0]  mul_b;
    logic [K-1:0]  mul_m;
    logic [K-1:0]  mul_p;
    logic          mul_done;
    logic [3:0]    dbg;

    montgomery_modexp_ctrl #(.K_BITS(K), .E_BITS(EB)) dut (
        .i_Clk       (clk),
        .i_Rst       (rst),
        .i_Start     (start),
        .i_X         (x),
        .i_E         (e),
        .i_m         (m),
        .i_R2        (r2),
        .o_Result    (result),
        .o_Done      (done),
        .o_Busy      (busy),
        .o_Mul_Start (mul_start),
        .o_Mul_A     (mul_a),
        .o_Mul_B     (mul_b),
        .o_Mul_m     (mul_m),
        .i_Mul_P     (mul_p),
        .i_Mul_Done  (mul_done),
        .o_Dbg_State (dbg)
    );

    // ---------------- scoreboard counters ----------------
    int pass_cnt = 0;
    int total_cnt = 0;
    int fail_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference Montgomery product a*b*2^-8 mod mm, fully reduced.
    function automatic logic [K-1:0] mmm(input logic [K-1:0] a, input logic [K-1:0] b,
                                         input logic [K-1:0] mm);
        int t;
        logic [K-1:0] res;
        res = 8'hFF;
        t = (int'(a) * int'(b)) % int'(mm);
        for (int r = 0; r < int'(mm); r++) begin
            if (((r * 256) % int'(mm)) == t) res = K'(r);
        end
        return res;
    endfunction

    // ---------------- multiplier model + handshake monitor ----------------
    logic          lat_rand = 1'b0;
    logic          gap_chk_en = 1'b1;
    logic          inject_en = 1'b0;
    int            inject_at = 0;
    int            rises = 0;

    logic          mdl_busy;
    int            mdl_cnt;
    logic [K-1:0]  mdl_a, mdl_b, mdl_m;
    logic          prev_start;
    logic [K-1:0]  prev_a, prev_b, prev_m;
    logic          have_prev;
    int            gap;

    always @(negedge clk) begin
        if (rst) begin
            mdl_busy   = 1'b0;
            mdl_cnt    = 0;
            mul_done   = 1'b0;
            mul_p      = '0;
            prev_start = 1'b0;
            prev_a     = '0;
            prev_b     = '0;
            prev_m     = '0;
            have_prev  = 1'b0;
            gap        = 0;
        end else begin
            // Monitor: mul_done here is still the level the DUT saw at the
            // preceding rising edge.
            if (!busy) begin
                have_prev = 1'b0;
                gap = 0;
            end
            if (mul_start && !prev_start) begin
                rises++;
                check("start_rise_while_done", {31'd0, mul_done}, 32'd0);
                if (gap_chk_en && have_prev) check("issue_gap", gap, 1);
                have_prev = 1'b1;
                gap = 0;
            end
            if (!mul_start && busy) gap++;
            if ((mul_start && prev_start) || mul_done) begin
                check("stable_a", {24'd0, mul_a}, {24'd0, prev_a});
                check("stable_b", {24'd0, mul_b}, {24'd0, prev_b});
                check("stable_m", {24'd0, mul_m}, {24'd0, prev_m});
            end
            prev_start = mul_start;
            prev_a     = mul_a;
            prev_b     = mul_b;
            prev_m     = mul_m;

            // Model
            if (!mdl_busy && !mul_done && mul_start) begin
                mdl_busy = 1'b1;
                mdl_a    = mul_a;
                mdl_b    = mul_b;
                mdl_m    = mul_m;
                mdl_cnt  = lat_rand ? int'($urandom_range(0, 5)) : 0;
            end else if (mdl_busy) begin
                if (mdl_cnt == 0) begin
                    mul_p = mmm(mdl_a, mdl_b, mdl_m);
                    if (inject_en && rises == inject_at) mul_p = mul_p + mdl_m;
                    mul_done = 1'b1;
                    mdl_busy = 1'b0;
                end else begin
                    mdl_cnt--;
                end
            end else if (mul_done && !mul_start) begin
                mul_done = 1'b0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic run(input logic [K-1:0] xv, input logic [EB-1:0] ev,
                       input logic [K-1:0] exp_res, input int exp_mul, input string tag);
        int base;
        int budget;
        @(negedge clk);
        x = xv; e = ev; m = MOD; r2 = R2; start = 1'b1;
        base = rises;
        @(negedge clk);
        check({tag, "_busy_up"},  {31'd0, busy}, 32'd1);
        check({tag, "_start_up"}, {31'd0, mul_start}, 32'd1);
        check({tag, "_first_a"},  {24'd0, mul_a}, {24'd0, xv});
        check({tag, "_first_b"},  {24'd0, mul_b}, {24'd0, R2});
        check({tag, "_mod"},      {24'd0, mul_m}, {24'd0, MOD});
        // Inputs must be ignored once the run has started.
        x = 8'hAA; e = 8'h55; m = 8'd7; r2 = 8'd1;
        budget = 0;
        while (!done && budget < 3000) begin
            @(negedge clk);
            budget++;
        end
        check({tag, "_done"},   {31'd0, done}, 32'd1);
        check({tag, "_result"}, {24'd0, result}, {24'd0, exp_res});
        check({tag, "_mults"},  rises - base, exp_mul);
        check({tag, "_busy_dn"}, {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clk);
        check({tag, "_done_held"}, {31'd0, done}, 32'd1);
        start = 1'b0;
        @(negedge clk);
        check({tag, "_done_clr"}, {31'd0, done}, 32'd0);
        check({tag, "_res_hold"}, {24'd0, result}, {24'd0, exp_res});
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int budget;
        int base;
        rst = 1'b1; start = 1'b0; x = '0; e = '0; m = '0; r2 = '0;
        repeat (2) @(negedge clk);
        check("rst_result", {24'd0, result}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_mstart", {31'd0, mul_start}, 32'd0);
        check("rst_ma", {24'd0, mul_a}, 32'd0);
        check("rst_mb", {24'd0, mul_b}, 32'd0);
        check("rst_mm", {24'd0, mul_m}, 32'd0);
        check("rst_state", {28'd0, dbg}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run(8'd2,  8'd5,   8'd6, 13, "x2e5");
        run(8'd2,  8'd255, 8'd8, 19, "x2e255");
        run(8'd7,  8'd0,   8'd1, 11, "x7e0");
        run(8'd0,  8'd3,   8'd0, 13, "x0e3");
        run(8'd12, 8'd2,   8'd1, 12, "x12e2");

        // FROM multiply (the 13th of this run) comes back as P+m.
        inject_en = 1'b1;
        inject_at = rises + 13;
        run(8'd2, 8'd5, 8'd6, 13, "corr");
        inject_en = 1'b0;

        // Stretched, random multiplier latency.
        lat_rand = 1'b1; gap_chk_en = 1'b0;
        run(8'd2, 8'd5,   8'd6, 13, "rnd_e5");
        run(8'd2, 8'd255, 8'd8, 19, "rnd_e255");
        lat_rand = 1'b0; gap_chk_en = 1'b1;

        // Asynchronous reset during the 5th multiply.
        @(negedge clk);
        x = 8'd2; e = 8'd5; m = MOD; r2 = R2; start = 1'b1;
        base = rises;
        budget = 0;
        while ((rises - base) < 5 && budget < 500) begin
            @(negedge clk);
            budget++;
        end
        check("rst5_reached", rises - base, 5);
        check("rst5_busy_before", {31'd0, busy}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rst5_result", {24'd0, result}, 32'd0);
        check("rst5_done", {31'd0, done}, 32'd0);
        check("rst5_busy", {31'd0, busy}, 32'd0);
        check("rst5_mstart", {31'd0, mul_start}, 32'd0);
        check("rst5_ma", {24'd0, mul_a}, 32'd0);
        check("rst5_mb", {24'd0, mul_b}, 32'd0);
        check("rst5_mm", {24'd0, mul_m}, 32'd0);
        check("rst5_state", {28'd0, dbg}, 32'd0);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        run(8'd3, 8'd4, 8'd3, 12, "after_rst");

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
